// File: rtl/dmem_loader_pkg.sv
// Shared constants and the loader's state encoding.
package dmem_loader_pkg;
  localparam int DATA_W     = 32;
  localparam int DMEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    LD_LEN_HI = 2'd0,
    LD_LEN_LO = 2'd1,
    LD_DATA   = 2'd2,
    LD_DONE   = 2'd3
  } ld_state_e;
endpackage

// File: rtl/dmem_loader_if.sv
// Byte-stream input plus dmem write port of the boot loader.
interface dmem_loader_if #(parameter int DATA_W = 32);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       a;
  logic [DATA_W-1:0] wd;
  logic              we;

  // master: stream source / dmem observer; slave: the loader itself
  modport master (output in_data, in_valid, input in_ready, a, wd, we);
  modport slave  (input in_data, in_valid, output in_ready, a, wd, we);
endinterface

// File: rtl/dmem_loader.sv
// Boot-time image loader: 16-bit word count then big-endian words into dmem,
// holding the CPU in reset until the final word has been written.
module dmem_loader #(
  parameter int DMEM_DEPTH = dmem_loader_pkg::DMEM_DEPTH,
  parameter int DATA_W     = dmem_loader_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_loader_if.slave  bus,
  input  logic          start,
  output logic          cpu_hold,
  output logic          done,
  output logic          overflow
);
  import dmem_loader_pkg::*;

  ld_state_e         state, state_nxt;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [15:0]       word_cnt_inc;
  logic [23:0]       shreg;
  logic [1:0]        byte_cnt;
  logic [15:0]       a_q;
  logic [DATA_W-1:0] wd_q;
  logic              we_q;
  logic              take;
  logic              word_end;
  logic              fits;

  assign bus.in_ready = (state != LD_DONE);
  assign bus.a        = a_q;
  assign bus.wd       = wd_q;
  assign bus.we       = we_q;

  assign take         = bus.in_valid && bus.in_ready;
  assign word_end     = take && (state == LD_DATA) && (byte_cnt == 2'd3);
  assign word_cnt_inc = word_cnt + 16'd1;
  assign fits         = 32'(word_cnt) < DMEM_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_LEN_HI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_LEN_HI: if (take) state_nxt = LD_LEN_LO;
      LD_LEN_LO: if (take) state_nxt = ({len[15:8], bus.in_data} == 16'd0) ? LD_DONE : LD_DATA;
      LD_DATA:   if (word_end && (word_cnt_inc == len)) state_nxt = LD_DONE;
      LD_DONE:   if (start) state_nxt = LD_LEN_HI;
      default:   state_nxt = LD_LEN_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      word_cnt <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        LD_LEN_HI: if (take) len[15:8] <= bus.in_data;
        LD_LEN_LO: if (take) len[7:0]  <= bus.in_data;
        LD_DATA: if (take) begin
          shreg    <= {shreg[15:0], bus.in_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            a_q      <= word_cnt;
            wd_q     <= {shreg, bus.in_data};
            // words past the end of dmem are consumed but dropped
            if (fits) we_q     <= 1'b1;
            else      overflow <= 1'b1;
            word_cnt <= word_cnt_inc;
          end
        end
        LD_DONE: begin
          // done/cpu_hold lag DONE entry by one cycle so the last write lands first
          if (start) begin
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
          end else begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_loader.sv
// Randomized self-checking bench for dmem_loader against a byte-position model.
module tb_dmem_loader;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, overflow;

  dmem_loader_if #(.DATA_W(32)) bus ();

  dmem_loader #(.DMEM_DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start(start),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] gw [7] = '{32'h070c0001, 32'h00020003, 32'h01020105, 32'h02030204,
                          32'h02050206, 32'h03040406, 32'h05060000};
  logic [7:0]  img [$];
  logic [47:0] wlog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: outcome of each accepted byte follows from its position in the image.
  int          pos = 0;
  logic [15:0] mlen = '0;
  logic [31:0] masm = '0;
  bit          mdone = 1'b0;
  logic        exp_we = 1'b0, exp_done = 1'b0, exp_hold = 1'b1, exp_ovf = 1'b0, exp_rdy = 1'b1;
  logic [15:0] exp_a = '0;
  logic [31:0] exp_wd = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pos = 0; mlen = '0; mdone = 1'b0; exp_we = 1'b0; exp_done = 1'b0;
      exp_hold = 1'b1; exp_ovf = 1'b0; exp_rdy = 1'b1;
    end else begin
      exp_we = 1'b0;
      if (mdone) begin
        if (start) begin
          mdone = 1'b0; pos = 0; mlen = '0; exp_ovf = 1'b0; exp_done = 1'b0;
        end else exp_done = 1'b1;
      end else if (bus.in_valid) begin
        if (pos == 0) mlen[15:8] = bus.in_data;
        else if (pos == 1) begin
          mlen[7:0] = bus.in_data;
          if (mlen == 16'd0) mdone = 1'b1;
        end else begin
          masm = {masm[23:0], bus.in_data};
          if ((pos - 2) % 4 == 3) begin
            int widx;
            widx   = (pos - 2) / 4;
            exp_a  = widx[15:0];
            exp_wd = masm;
            if (widx < DEPTH) exp_we = 1'b1;
            else              exp_ovf = 1'b1;
            if (widx + 1 == int'(mlen)) mdone = 1'b1;
          end
        end
        pos++;
      end
      exp_hold = !exp_done;
      exp_rdy  = !mdone;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("we", 32'(bus.we), 32'(exp_we));
    chk("done", 32'(done), 32'(exp_done));
    chk("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (exp_we) begin
      chk("a", 32'(bus.a), 32'(exp_a));
      chk("wd", bus.wd, exp_wd);
    end
    if (bus.we) wlog.push_back({bus.a, bus.wd});
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    start        = st;
    for (int t = 0; t < 50; t++) begin
      if (bus.in_ready) begin
        @(negedge clk);
        start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; errors++;
    $display("FAIL send_timeout got=in_ready_low want=accept t=%0t", $time);
  endtask

  task automatic push_word(input logic [31:0] w);
    img.push_back(w[31:24]); img.push_back(w[23:16]);
    img.push_back(w[15:8]);  img.push_back(w[7:0]);
  endtask

  task automatic build_img(input int n, input bit graph);
    logic [15:0] l;
    l = 16'(n);
    img.delete();
    img.push_back(l[15:8]);
    img.push_back(l[7:0]);
    for (int i = 0; i < n; i++) push_word(graph ? gw[i] : $urandom);
  endtask

  task automatic send_img(input int gapmax);
    foreach (img[i]) send_byte(img[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, 1'b0);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_a_wd_we", {15'd0, bus.we, bus.a} ^ bus.wd, 32'd0);
    rst_n = 1'b1;

    // graph image, back-to-back bytes
    wlog.delete();
    build_img(7, 1'b1);
    foreach (img[i]) send_byte(img[i], 0, 1'b0);
    bus.in_valid = 1'b0;
    chk("graph_last_we", 32'(bus.we), 32'd1);
    chk("graph_last_a", 32'(bus.a), 32'd6);
    @(negedge clk);
    chk("graph_done", 32'(done), 32'd1);
    chk("graph_hold", 32'(cpu_hold), 32'd0);
    chk("graph_nwr", wlog.size(), 32'd7);
    foreach (wlog[i]) begin
      chk("graph_a_lit", 32'(wlog[i][47:32]), i);
      chk("graph_wd_lit", wlog[i][31:0], gw[i]);
    end

    // same image with random idle gaps
    pulse_start();
    wlog.delete();
    send_img(3);
    repeat (3) @(negedge clk);
    chk("gap_nwr", wlog.size(), 32'd7);
    foreach (wlog[i]) chk("gap_wd_lit", wlog[i][31:0], gw[i]);

    // zero-length image
    pulse_start();
    wlog.delete();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    bus.in_valid = 1'b0;
    chk("len0_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_nwr", wlog.size(), 32'd0);

    // one word past the end of dmem
    pulse_start();
    wlog.delete();
    build_img(DEPTH + 1, 1'b0);
    send_img(1);
    repeat (3) @(negedge clk);
    chk("ovf_nwr", wlog.size(), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_done", 32'(done), 32'd1);
    pulse_start();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_rearm_hold", 32'(cpu_hold), 32'd1);

    // start ignored mid-image, then reset two bytes into word 3
    wlog.delete();
    build_img(5, 1'b0);
    for (int i = 0; i < 12; i++) send_byte(img[i], 0, i == 5);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_partial_nwr", wlog.size(), 32'd2);
    wlog.delete();
    build_img(2, 1'b0);
    send_img(2);
    repeat (3) @(negedge clk);
    chk("rst_new_nwr", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      chk("rst_new_a0", 32'(wlog[0][47:32]), 32'd0);
      chk("rst_new_a1", 32'(wlog[1][47:32]), 32'd1);
    end

    // start together with a valid byte in DONE
    wlog.delete();
    start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h00;
    chk("start_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("start_rearm_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    send_byte(8'h01, 0, 1'b0);
    push_word(32'hdeadbeef);
    for (int i = 0; i < 4; i++) send_byte(img[img.size() - 4 + i], 0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_nwr", wlog.size(), 32'd1);
    if (wlog.size() == 1) chk("start_wr", wlog[0][47:0] == {16'd0, 32'hdeadbeef}, 32'd1);

    // random images, some overrunning dmem
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      build_img(int'($urandom_range(1, DEPTH + 4)), 1'b0);
      send_img(int'($urandom_range(0, 2)));
      repeat (3) @(negedge clk);
      chk("rand_done", 32'(done), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
